// File: rtl/uart_tx_8n1_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_8n1_if                                            |
// | Desc     : FIFO read port between the TX byte FIFO and uart_tx_8n1.  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
interface uart_tx_8n1_if;
   logic       fifo_empty;
   logic [7:0] fifo_data;
   logic       fifo_rd_en;

   // master = transmitter (issues pops), slave = FIFO read side
   modport master (
      input  fifo_empty,
      input  fifo_data,
      output fifo_rd_en
   );

   modport slave (
      output fifo_empty,
      output fifo_data,
      input  fifo_rd_en
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_8n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : uart_tx_8n1                                               |
// | Desc     : Pops bytes from the TX FIFO and shifts them out as 8N1.   |
// |            Define UART_TX_EVEN_PARITY_EN for 8E1 framing.            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module uart_tx_8n1 #(
   parameter int CLKS_PER_BIT = 104
) (
   input  wire           i_clk,
   input  wire           i_reset,
   input  wire           i_tx_en,
   uart_tx_8n1_if.master fifo,
   output logic          o_tx,
   output logic          o_busy,
   output logic          o_tx_done
);

   localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(CLKS_PER_BIT - 1);

   localparam logic [2:0] c_st_idle   = 3'd0;
   localparam logic [2:0] c_st_fetch  = 3'd1;
   localparam logic [2:0] c_st_load   = 3'd2;
   localparam logic [2:0] c_st_start  = 3'd3;
   localparam logic [2:0] c_st_data   = 3'd4;
   localparam logic [2:0] c_st_stop   = 3'd5;
`ifdef UART_TX_EVEN_PARITY_EN
   localparam logic [2:0] c_st_parity = 3'd6;
`endif

   logic [2:0]         r_state;
   logic [c_cnt_w-1:0] r_cnt;
   logic [2:0]         r_bit_idx;
   logic [7:0]         r_shift;
   logic               r_tx;
   logic               r_rd_en;
`ifdef UART_TX_EVEN_PARITY_EN
   logic               r_parity;
`endif

   logic [2:0]         w_state_nxt;
   logic [c_cnt_w-1:0] w_cnt_nxt;
   logic [c_cnt_w-1:0] w_cnt_inc;
   logic [2:0]         w_bit_idx_nxt;
   logic [7:0]         w_shift_nxt;
   logic               w_tx_nxt;
   logic               w_rd_en_nxt;
   logic               w_bit_end;
   logic               w_start;

   assign w_bit_end = (r_cnt == c_cnt_last);
   assign w_cnt_inc = w_bit_end ? '0 : r_cnt + c_cnt_w'(1);
   assign w_start   = i_tx_en & ~fifo.fifo_empty;

   assign o_tx            = r_tx;
   assign fifo.fifo_rd_en = r_rd_en;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= c_st_idle;
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_tx      <= 1'b1;
         r_rd_en   <= 1'b0;
`ifdef UART_TX_EVEN_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_bit_idx <= w_bit_idx_nxt;
         r_shift   <= w_shift_nxt;
         r_tx      <= w_tx_nxt;
         r_rd_en   <= w_rd_en_nxt;
`ifdef UART_TX_EVEN_PARITY_EN
         if (r_state == c_st_load) begin
            r_parity <= ^fifo.fifo_data;
         end
`endif
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_start) w_state_nxt = c_st_fetch;
         c_st_fetch: w_state_nxt = c_st_load;
         c_st_load:  w_state_nxt = c_st_start;
         c_st_start: if (w_bit_end) w_state_nxt = c_st_data;
         c_st_data: begin
            if (w_bit_end && (r_bit_idx == 3'd7)) begin
`ifdef UART_TX_EVEN_PARITY_EN
               w_state_nxt = c_st_parity;
`else
               w_state_nxt = c_st_stop;
`endif
            end
         end
`ifdef UART_TX_EVEN_PARITY_EN
         c_st_parity: if (w_bit_end) w_state_nxt = c_st_stop;
`endif
         // A waiting byte is fetched straight from STOP, no idle cycle.
         c_st_stop:  if (w_bit_end) w_state_nxt = w_start ? c_st_fetch : c_st_idle;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   always_comb begin
      w_cnt_nxt     = '0;
      w_bit_idx_nxt = r_bit_idx;
      w_shift_nxt   = r_shift;
      w_tx_nxt      = r_tx;
      w_rd_en_nxt   = 1'b0;
      o_busy        = (r_state != c_st_idle);
      o_tx_done     = 1'b0;
      case (r_state)
         c_st_idle: begin
            w_tx_nxt    = 1'b1;
            w_rd_en_nxt = w_start;
         end
         c_st_load: begin
            w_shift_nxt = fifo.fifo_data;
            w_tx_nxt    = 1'b0;
         end
         c_st_start: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_bit_end) begin
               w_tx_nxt      = r_shift[0];
               w_bit_idx_nxt = '0;
            end
         end
         c_st_data: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_bit_end) begin
               if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_EVEN_PARITY_EN
                  w_tx_nxt = r_parity;
`else
                  w_tx_nxt = 1'b1;
`endif
               end else begin
                  w_tx_nxt      = r_shift[1];
                  w_shift_nxt   = {1'b0, r_shift[7:1]};
                  w_bit_idx_nxt = r_bit_idx + 3'd1;
               end
            end
         end
`ifdef UART_TX_EVEN_PARITY_EN
         c_st_parity: begin
            w_cnt_nxt = w_cnt_inc;
            if (w_bit_end) w_tx_nxt = 1'b1;
         end
`endif
         c_st_stop: begin
            w_cnt_nxt   = w_cnt_inc;
            o_tx_done   = w_bit_end;
            w_rd_en_nxt = w_bit_end & w_start;
         end
         default: ;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_8n1.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_uart_tx_8n1                                            |
// | Desc     : Random and directed bench for uart_tx_8n1 with FIFO model |
// |            and frame-level reference (honours UART_TX_EVEN_PARITY_EN)|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_uart_tx_8n1;

   localparam int c_clks_per_bit = 4;
`ifdef UART_TX_EVEN_PARITY_EN
   localparam int c_bits  = 11;
   localparam bit c_parity = 1'b1;
`else
   localparam int c_bits  = 10;
   localparam bit c_parity = 1'b0;
`endif
   localparam int c_frame_cycles = c_bits * c_clks_per_bit;

   logic clk = 1'b0;
   logic rst;
   logic tx_en;
   logic tx;
   logic busy;
   logic tx_done;

   uart_tx_8n1_if bus ();

   uart_tx_8n1 #(.CLKS_PER_BIT(c_clks_per_bit)) dut (
      .i_clk     (clk),
      .i_reset   (rst),
      .i_tx_en   (tx_en),
      .fifo      (bus.master),
      .o_tx      (tx),
      .o_busy    (busy),
      .o_tx_done (tx_done)
   );

   initial forever #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference frame: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic exp_bit(input logic [7:0] b, input int k);
      int ones;
      ones = 0;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      if (c_parity && k == 9) return logic'(ones % 2);
      return 1'b1;
   endfunction

   // FIFO model: main writes mem/wr_ptr, monitor advances rd_ptr
   logic [7:0] mem [0:1023];
   int         wr_ptr = 0;
   int         rd_ptr = 0;
   assign bus.fifo_empty = (wr_ptr == rd_ptr);

   logic [7:0] q_exp [$];
   int         q_gaps [$];
   int         n_pops    = 0;
   int         n_frames  = 0;
   int         since_pop = 1000;
   int         gap       = 1000;
   int         frame_cyc = 0;
   bit         in_frame  = 1'b0;
   bit         prev_rd   = 1'b0;
   logic [7:0] pend_byte = 8'h00;
   logic [7:0] cur_byte  = 8'h00;

   always @(negedge clk) begin
      if (rst) begin
         in_frame  = 1'b0;
         frame_cyc = 0;
         since_pop = 1000;
         gap       = 1000;
         prev_rd   = 1'b0;
         q_exp.delete();
         bus.fifo_data = 8'($urandom);
      end else begin
         // read data is valid only during the cycle after the pop
         if (prev_rd) bus.fifo_data = pend_byte;
         else         bus.fifo_data = 8'($urandom);
         if (bus.fifo_rd_en) begin
            check("rd_back_to_back", 32'(prev_rd), 0);
            check("rd_when_empty", 32'(wr_ptr == rd_ptr), 0);
            n_pops++;
            since_pop = 0;
            if (wr_ptr != rd_ptr) begin
               pend_byte = mem[rd_ptr % 1024];
               rd_ptr++;
               q_exp.push_back(pend_byte);
            end
         end else if (since_pop < 1000) begin
            since_pop++;
         end
         prev_rd = bus.fifo_rd_en;

         if (in_frame) begin
            frame_cyc++;
         end else if (tx == 1'b0) begin
            check("start_latency", since_pop, 2);
            in_frame  = 1'b1;
            frame_cyc = 1;
            q_gaps.push_back(gap);
            if (q_exp.size() > 0) begin
               cur_byte = q_exp.pop_front();
            end else begin
               check("start_without_pop", 0, 1);
               cur_byte = 8'h00;
            end
         end else if (gap < 1000) begin
            gap++;
         end

         if (in_frame) begin
            check("busy_in_frame", 32'(busy), 1);
            check("tx_done", 32'(tx_done), 32'(frame_cyc == c_frame_cycles));
            if (frame_cyc % c_clks_per_bit == c_clks_per_bit / 2)
               check("line_bit", 32'(tx), 32'(exp_bit(cur_byte, frame_cyc / c_clks_per_bit)));
            if (frame_cyc == c_frame_cycles) begin
               in_frame = 1'b0;
               n_frames++;
               gap = 0;
            end
         end else begin
            check("tx_done_idle", 32'(tx_done), 0);
         end
      end
   end

   task automatic push(input logic [7:0] b);
      @(negedge clk);
      #1;
      mem[wr_ptr % 1024] = b;
      wr_ptr++;
   endtask

   task automatic wait_idle(input string tag);
      int t;
      t = 0;
      do begin
         @(negedge clk);
         #2;
         t++;
      end while ((busy || in_frame || wr_ptr != rd_ptr) && t < 5000);
      check({tag, "_timeout"}, 32'(t < 5000), 1);
      check({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic wait_frame_cyc(input int target);
      int t;
      t = 0;
      while (!(in_frame && frame_cyc == target) && t < 3000) begin
         @(posedge clk);
         t++;
      end
      check("wait_frame_timeout", 32'(t < 3000), 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   int p0;
   int f0;
   int n;

   initial begin
      rst   = 1'b1;
      tx_en = 1'b0;
      repeat (3) @(negedge clk);
      #2;
      check("rst_tx", 32'(tx), 1);
      check("rst_busy", 32'(busy), 0);
      check("rst_rd_en", 32'(bus.fifo_rd_en), 0);
      check("rst_done", 32'(tx_done), 0);
      rst = 1'b0;
      repeat (5) @(negedge clk);

      // single byte
      #1 tx_en = 1'b1;
      p0 = n_pops; f0 = n_frames;
      push(8'hA5);
      wait_idle("a5");
      check("a5_pops", n_pops - p0, 1);
      check("a5_frames", n_frames - f0, 1);

      // back-to-back
      q_gaps.delete();
      p0 = n_pops; f0 = n_frames;
      push(8'h00); push(8'hFF); push(8'h55);
      wait_idle("b2b");
      check("b2b_pops", n_pops - p0, 3);
      check("b2b_frames", n_frames - f0, 3);
      check("b2b_gap1", q_gaps[1], 2);
      check("b2b_gap2", q_gaps[2], 2);

      // enable gating
      tx_en = 1'b0;
      p0 = n_pops; f0 = n_frames;
      push(8'h3C);
      repeat (40) @(negedge clk);
      #2;
      check("gate_pops", n_pops - p0, 0);
      check("gate_tx", 32'(tx), 1);
      tx_en = 1'b1;
      wait_frame_cyc(5);
      #3 tx_en = 1'b0;
      push(8'hC3);
      repeat (3 * c_frame_cycles) @(negedge clk);
      #2;
      check("drop_pops", n_pops - p0, 1);
      check("drop_frames", n_frames - f0, 1);
      check("drop_left", wr_ptr - rd_ptr, 1);
      tx_en = 1'b1;
      wait_idle("drop");
      check("drop_total", n_frames - f0, 2);

      // late arrival during the last STOP cycle
      push(8'h96);
      wait_frame_cyc(c_frame_cycles - 1);
      q_gaps.delete();
      push(8'h69);
      wait_idle("late");
      check("late_gaps", q_gaps.size(), 1);
      check("late_gap", q_gaps[0], 2);

`ifdef UART_TX_EVEN_PARITY_EN
      p0 = n_pops;
      push(8'h07); push(8'h03);
      wait_idle("parity");
      check("parity_pops", n_pops - p0, 2);
`endif

      // randomized traffic with random arrival times
      for (int it = 0; it < 8; it++) begin
         p0 = n_pops; f0 = n_frames;
         n = int'($urandom_range(1, 3));
         for (int j = 0; j < n; j++) begin
            repeat ($urandom_range(0, 45)) @(negedge clk);
            push(8'($urandom));
         end
         wait_idle("rand");
         check("rand_pops", n_pops - p0, n);
         check("rand_frames", n_frames - f0, n);
      end

      // reset in the middle of the data bits
      push(8'h00);
      wait_frame_cyc(10);
      #3;
      check("pre_rst_tx", 32'(tx), 0);
      rst = 1'b1;
      #1;
      check("mid_rst_tx", 32'(tx), 1);
      check("mid_rst_busy", 32'(busy), 0);
      repeat (2) @(negedge clk);
      #1 rst = 1'b0;
      p0 = n_pops;
      repeat (30) @(negedge clk);
      #2;
      check("post_rst_pops", n_pops - p0, 0);
      check("post_rst_tx", 32'(tx), 1);
      check("post_rst_busy", 32'(busy), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
